// File: rtl/mem_pkg.sv
// Shared types for the memory access sequencer: command opcodes and FSM states.
package mem_pkg;

  localparam logic [1:0] OP_ENC_LOAD  = 2'b00;
  localparam logic [1:0] OP_ENC_STORE = 2'b01;
  localparam logic [1:0] OP_ENC_COPY  = 2'b10;
  localparam logic [1:0] OP_ENC_FILL  = 2'b11;

  typedef enum logic [1:0] {
    OP_LOAD  = OP_ENC_LOAD,
    OP_STORE = OP_ENC_STORE,
    OP_COPY  = OP_ENC_COPY,
    OP_FILL  = OP_ENC_FILL
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE,
    ST_CP_RD,
    ST_CP_WR,
    ST_FILL
  } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Sequencer in front of data_mem: runs single loads/stores and block copy/fill
// commands, one at a time, and returns one response pulse per command.
// The DataIn register doubles as the copy byte register: a byte read in CP_RD
// lands directly in DataIn for the following CP_WR cycle.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_src,
  input  logic [DW-1:0] req_data,
  input  logic [7:0]    req_len,
  output logic          resp_valid,
  output logic [DW-1:0] resp_data,
  output logic          busy,
  output logic [AW-1:0] DataAddress,
  output logic          ReadMem,
  output logic          WriteMem,
  output logic [DW-1:0] DataIn,
  input  logic [DW-1:0] DataOut
);

  state_t        r_state, w_state_next;
  logic [7:0]    r_idx, w_idx_next;
  logic [7:0]    r_len, w_len_next;
  logic [AW-1:0] r_dst, w_dst_next;
  logic [AW-1:0] r_src, w_src_next;
  logic          r_read, w_read_next;
  logic          r_write, w_write_next;
  logic [AW-1:0] r_addr, w_addr_next;
  logic [DW-1:0] r_din, w_din_next;
  logic          r_resp_valid, w_resp_valid_next;
  logic [DW-1:0] r_resp_data, w_resp_data_next;

  op_t           w_op;
  logic [7:0]    w_idx_inc;
  logic          w_last;

  assign w_op      = op_t'(req_op);
  assign w_idx_inc = r_idx + 8'd1;
  assign w_last    = (w_idx_inc == r_len);

  assign req_ready   = (r_state == ST_IDLE);
  assign busy        = ~req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_data   = r_resp_data;
  assign DataAddress = r_addr;
  assign ReadMem     = r_read;
  assign WriteMem    = r_write;
  assign DataIn      = r_din;

  // Next-state and next memory-port values; strobes and response default low.
  always_comb begin
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_len_next        = r_len;
    w_dst_next        = r_dst;
    w_src_next        = r_src;
    w_read_next       = 1'b0;
    w_write_next      = 1'b0;
    w_addr_next       = r_addr;
    w_din_next        = r_din;
    w_resp_valid_next = 1'b0;
    w_resp_data_next  = r_resp_data;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_dst_next = req_addr;
          w_src_next = req_src;
          w_len_next = req_len;
          w_idx_next = '0;
          case (w_op)
            OP_LOAD: begin
              w_state_next = ST_LOAD;
              w_read_next  = 1'b1;
              w_addr_next  = req_addr;
            end
            OP_STORE: begin
              w_state_next = ST_STORE;
              w_write_next = 1'b1;
              w_addr_next  = req_addr;
              w_din_next   = req_data;
            end
            OP_COPY: begin
              if (req_len == 8'd0) begin
                w_resp_valid_next = 1'b1;
                w_resp_data_next  = '0;
              end else begin
                w_state_next = ST_CP_RD;
                w_read_next  = 1'b1;
                w_addr_next  = req_src;
              end
            end
            OP_FILL: begin
              if (req_len == 8'd0) begin
                w_resp_valid_next = 1'b1;
                w_resp_data_next  = '0;
              end else begin
                w_state_next = ST_FILL;
                w_write_next = 1'b1;
                w_addr_next  = req_addr;
                w_din_next   = req_data;
              end
            end
          endcase
        end
      end
      ST_LOAD: begin
        w_state_next      = ST_IDLE;
        w_resp_valid_next = 1'b1;
        w_resp_data_next  = DataOut;
      end
      ST_STORE: begin
        w_state_next      = ST_IDLE;
        w_resp_valid_next = 1'b1;
        w_resp_data_next  = '0;
      end
      ST_CP_RD: begin
        w_state_next = ST_CP_WR;
        w_write_next = 1'b1;
        w_addr_next  = r_dst + AW'(r_idx);
        w_din_next   = DataOut;
      end
      ST_CP_WR: begin
        w_idx_next = w_idx_inc;
        if (w_last) begin
          w_state_next      = ST_IDLE;
          w_resp_valid_next = 1'b1;
          w_resp_data_next  = DW'(r_len);
        end else begin
          w_state_next = ST_CP_RD;
          w_read_next  = 1'b1;
          w_addr_next  = r_src + AW'(w_idx_inc);
        end
      end
      ST_FILL: begin
        w_idx_next = w_idx_inc;
        if (w_last) begin
          w_state_next      = ST_IDLE;
          w_resp_valid_next = 1'b1;
          w_resp_data_next  = DW'(r_len);
        end else begin
          w_write_next = 1'b1;
          w_addr_next  = r_dst + AW'(w_idx_inc);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, latched command fields and registered memory-port outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_len        <= '0;
      r_dst        <= '0;
      r_src        <= '0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_din        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_len        <= w_len_next;
      r_dst        <= w_dst_next;
      r_src        <= w_src_next;
      r_read       <= w_read_next;
      r_write      <= w_write_next;
      r_addr       <= w_addr_next;
      r_din        <= w_din_next;
      r_resp_valid <= w_resp_valid_next;
      r_resp_data  <= w_resp_data_next;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit connected to a behavioural data_mem; expected
// responses come from a byte-level memory model and a response queue.
module tb_mem_access_unit;

  localparam logic [1:0] OPL = 2'b00;
  localparam logic [1:0] OPS = 2'b01;
  localparam logic [1:0] OPC = 2'b10;
  localparam logic [1:0] OPF = 2'b11;

  logic       CLK;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr;
  logic [7:0] req_src;
  logic [7:0] req_data;
  logic [7:0] req_len;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       busy;
  logic [7:0] DataAddress;
  logic       ReadMem;
  logic       WriteMem;
  logic [7:0] DataIn;
  wire  [7:0] DataOut;

  int checks;
  int errors;
  bit memInit;

  logic [7:0] mem   [256];
  logic [7:0] model [256];
  logic [7:0] expQ[$];
  logic [1:0] strobeQ[$];
  logic [7:0] writeAddrQ[$];

  mem_access_unit #(.AW(8), .DW(8)) dut (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_src(req_src), .req_data(req_data), .req_len(req_len),
    .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
    .DataAddress(DataAddress), .ReadMem(ReadMem), .WriteMem(WriteMem),
    .DataIn(DataIn), .DataOut(DataOut)
  );

  // Behavioural data_mem: combinational read while ReadMem, write on the edge.
  assign DataOut = ReadMem ? mem[DataAddress] : 8'bz;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory contents: pattern load during reset, then DUT writes.
  always @(posedge CLK) begin
    if (memInit) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
    end else if (WriteMem) begin
      mem[DataAddress] <= DataIn;
    end
  end

  function automatic logic [7:0] popExp();
    if (expQ.size() == 0) return 8'hxx;
    return expQ.pop_front();
  endfunction

  // Drive one command, update the model and queue its expected response.
  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] addr,
                               input logic [7:0] src, input logic [7:0] data,
                               input logic [7:0] len);
    @(negedge CLK);
    req_op = op; req_addr = addr; req_src = src; req_data = data; req_len = len;
    req_valid = 1'b1;
    case (op)
      OPL: expQ.push_back(model[addr]);
      OPS: begin model[addr] = data; expQ.push_back(8'h00); end
      OPC: begin
        for (int i = 0; i < int'(len); i++) model[8'(addr + 8'(i))] = model[8'(src + 8'(i))];
        expQ.push_back(len);
      end
      default: begin
        for (int i = 0; i < int'(len); i++) model[8'(addr + 8'(i))] = data;
        expQ.push_back(len);
      end
    endcase
    @(posedge CLK);
    #1 req_valid = 1'b0;
  endtask

  // Observe cycles after acceptance until the response pulse or the limit.
  task automatic checkOutput(input int limit, output int cycles, output bit got,
                             output logic [7:0] data);
    strobeQ.delete();
    writeAddrQ.delete();
    got = 1'b0; cycles = 0; data = 8'h00;
    while (!got && cycles < limit) begin
      @(negedge CLK);
      cycles++;
      if (resp_valid === 1'b1) begin
        got = 1'b1;
        data = resp_data;
      end else begin
        strobeQ.push_back({ReadMem, WriteMem});
        if (WriteMem === 1'b1) writeAddrQ.push_back(DataAddress);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; memInit = 1'b1; req_valid = 1'b0;
    req_op = OPL; req_addr = '0; req_src = '0; req_data = '0; req_len = '0;
    for (int i = 0; i < 256; i++) model[i] = 8'(i) ^ 8'hA5;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({req_ready, busy, resp_valid, ReadMem, WriteMem} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 10000", {req_ready, busy, resp_valid, ReadMem, WriteMem});
    end
    checks++;
    if ({DataAddress, DataIn, resp_data} !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected 000000", {DataAddress, DataIn, resp_data});
    end
    reset = 1'b0; memInit = 1'b0;
  endtask

  task automatic test_store_load();
    int cyc; bit got; logic [7:0] d, e; int nw, nr;
    applyStimulus(OPS, 8'h10, 8'h00, 8'hFE, 8'd0);
    checkOutput(10, cyc, got, d);
    e = popExp();
    nw = 0;
    foreach (strobeQ[k]) if (strobeQ[k] == 2'b01) nw++;
    checks++;
    if (!got || cyc != 2 || nw != 1 || d !== e) begin
      errors++;
      $display("[TB] FAIL store: got=%0d cyc=%0d writes=%0d data=%h expected 1/2/1/%h", got, cyc, nw, d, e);
    end
    checks++;
    if (mem[8'h10] !== model[8'h10]) begin
      errors++;
      $display("[TB] FAIL store_mem: got %h expected %h", mem[8'h10], model[8'h10]);
    end
    applyStimulus(OPL, 8'h10, 8'h00, 8'h00, 8'd0);
    checkOutput(10, cyc, got, d);
    e = popExp();
    nr = 0;
    foreach (strobeQ[k]) if (strobeQ[k] == 2'b10) nr++;
    checks++;
    if (!got || cyc != 2 || nr != 1 || d !== 8'hFE || d !== e) begin
      errors++;
      $display("[TB] FAIL load: got=%0d cyc=%0d reads=%0d data=%h expected 1/2/1/fe", got, cyc, nr, d);
    end
  endtask

  task automatic test_fill();
    int cyc; bit got; logic [7:0] d, e; bit bad;
    applyStimulus(OPF, 8'h20, 8'h00, 8'h5A, 8'd4);
    checkOutput(20, cyc, got, d);
    e = popExp();
    checks++;
    if (!got || cyc != 5 || d !== 8'd4 || d !== e) begin
      errors++;
      $display("[TB] FAIL fill_resp: got=%0d cyc=%0d data=%h expected 1/5/04", got, cyc, d);
    end
    bad = (writeAddrQ.size() != 4);
    for (int i = 0; i < 4 && i < writeAddrQ.size(); i++)
      if (writeAddrQ[i] !== 8'(8'h20 + 8'(i))) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL fill_addrs: got %0d writes expected 4 at 20..23", writeAddrQ.size());
    end
    bad = 1'b0;
    for (int i = 8'h20; i <= 8'h24; i++) if (mem[i] !== model[i]) bad = 1'b1;
    checks++;
    if (bad || mem[8'h23] !== 8'h5A || mem[8'h24] !== (8'h24 ^ 8'hA5)) begin
      errors++;
      $display("[TB] FAIL fill_mem: got M23=%h M24=%h expected 5a/%h", mem[8'h23], mem[8'h24], 8'h24 ^ 8'hA5);
    end
  endtask

  task automatic test_copy();
    int cyc; bit got; logic [7:0] d, e; bit bad;
    applyStimulus(OPC, 8'h40, 8'h20, 8'h00, 8'd4);
    checkOutput(30, cyc, got, d);
    e = popExp();
    checks++;
    if (!got || cyc != 9 || d !== 8'd4 || d !== e) begin
      errors++;
      $display("[TB] FAIL copy_resp: got=%0d cyc=%0d data=%h expected 1/9/04", got, cyc, d);
    end
    bad = (strobeQ.size() != 8);
    foreach (strobeQ[k]) if (strobeQ[k] !== ((k % 2 == 0) ? 2'b10 : 2'b01)) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL copy_strobes: got %0d cycles expected 8 alternating", strobeQ.size());
    end
    bad = 1'b0;
    for (int i = 8'h40; i < 8'h44; i++) if (mem[i] !== model[i] || mem[i] !== 8'h5A) bad = 1'b1;
    checks++;
    if (bad || mem[8'h44] !== model[8'h44]) begin
      errors++;
      $display("[TB] FAIL copy_mem: got M40=%h M44=%h expected 5a/%h", mem[8'h40], mem[8'h44], model[8'h44]);
    end
    @(negedge CLK);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL copy_single_resp: got resp_valid %b expected 0", resp_valid);
    end
  endtask

  task automatic test_wrap_and_zero();
    int cyc; bit got; logic [7:0] d, e;
    applyStimulus(OPF, 8'hFE, 8'h00, 8'h11, 8'd3);
    checkOutput(20, cyc, got, d);
    e = popExp();
    checks++;
    if (!got || d !== 8'd3 || d !== e || writeAddrQ.size() != 3) begin
      errors++;
      $display("[TB] FAIL wrap_resp: got=%0d data=%h writes=%0d expected 1/03/3", got, d, writeAddrQ.size());
    end else begin
      checks++;
      if (writeAddrQ[0] !== 8'hFE || writeAddrQ[1] !== 8'hFF || writeAddrQ[2] !== 8'h00) begin
        errors++;
        $display("[TB] FAIL wrap_addrs: got %h %h %h expected fe ff 00", writeAddrQ[0], writeAddrQ[1], writeAddrQ[2]);
      end
    end
    checks++;
    if (mem[8'hFE] !== 8'h11 || mem[8'hFF] !== 8'h11 || mem[8'h00] !== 8'h11 || mem[8'h01] !== model[8'h01]) begin
      errors++;
      $display("[TB] FAIL wrap_mem: got %h %h %h %h expected 11 11 11 %h", mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01], model[8'h01]);
    end
    applyStimulus(OPC, 8'h80, 8'h20, 8'h00, 8'd0);
    checkOutput(10, cyc, got, d);
    e = popExp();
    checks++;
    if (!got || cyc != 1 || d !== 8'h00 || d !== e || ReadMem !== 1'b0 || WriteMem !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_len: got=%0d cyc=%0d data=%h rd=%b wr=%b expected 1/1/00/0/0", got, cyc, d, ReadMem, WriteMem);
    end
  endtask

  task automatic test_reset_abort();
    int cyc; bit got; logic [7:0] d, e; bit sawResp;
    @(negedge CLK);
    req_op = OPC; req_addr = 8'h60; req_src = 8'h20; req_len = 8'd8; req_data = 8'h00;
    req_valid = 1'b1;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge CLK);
    model[8'h60] = model[8'h20];
    reset = 1'b1;
    @(negedge CLK);
    checks++;
    if ({req_ready, busy, resp_valid, ReadMem, WriteMem} !== 5'b10000 || {DataAddress, DataIn, resp_data} !== 24'h0) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got %b %h expected 10000 000000",
               {req_ready, busy, resp_valid, ReadMem, WriteMem}, {DataAddress, DataIn, resp_data});
    end
    reset = 1'b0;
    sawResp = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (resp_valid !== 1'b0 || WriteMem !== 1'b0) sawResp = 1'b1;
    end
    checks++;
    if (sawResp || mem[8'h60] !== model[8'h60] || mem[8'h61] !== model[8'h61]) begin
      errors++;
      $display("[TB] FAIL abort_quiet: activity=%b M60=%h M61=%h expected 0/%h/%h", sawResp, mem[8'h60], mem[8'h61], model[8'h60], model[8'h61]);
    end
    applyStimulus(OPL, 8'h60, 8'h00, 8'h00, 8'd0);
    checkOutput(10, cyc, got, d);
    e = popExp();
    checks++;
    if (!got || cyc != 2 || d !== e || d !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL abort_load: got=%0d cyc=%0d data=%h expected 1/2/5a", got, cyc, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    @(negedge CLK);
    req_op = OPL; req_addr = 8'h30; req_src = 8'h00; req_data = 8'h00; req_len = 8'd0;
    req_valid = 1'b1;
    expQ.push_back(model[8'h30]);
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0 || ReadMem !== 1'b1 || DataAddress !== 8'h30) begin
      errors++;
      $display("[TB] FAIL b2b_busy: got busy=%b rdy=%b rd=%b addr=%h expected 1/0/1/30", busy, req_ready, ReadMem, DataAddress);
    end
    req_op = OPS; req_addr = 8'h31; req_data = 8'h77;
    @(negedge CLK);
    e = popExp();
    checks++;
    if (resp_valid !== 1'b1 || req_ready !== 1'b1 || resp_data !== e) begin
      errors++;
      $display("[TB] FAIL b2b_load_resp: got vld=%b rdy=%b data=%h expected 1/1/%h", resp_valid, req_ready, resp_data, e);
    end
    model[8'h31] = 8'h77;
    expQ.push_back(8'h00);
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (WriteMem !== 1'b1 || DataAddress !== 8'h31 || DataIn !== 8'h77 || resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_store_issue: got wr=%b addr=%h din=%h vld=%b expected 1/31/77/0", WriteMem, DataAddress, DataIn, resp_valid);
    end
    @(negedge CLK);
    e = popExp();
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== e || mem[8'h31] !== model[8'h31] || mem[8'h30] !== model[8'h30]) begin
      errors++;
      $display("[TB] FAIL b2b_store_resp: got vld=%b data=%h M31=%h M30=%h expected 1/%h/77/%h",
               resp_valid, resp_data, mem[8'h31], mem[8'h30], e, model[8'h30]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_store_load();
    test_fill();
    test_copy();
    test_wrap_and_zero();
    test_reset_abort();
    test_back_to_back();
    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
